// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: two requester ports and one response port.
// The arbiter uses the slave modport; the traffic source and sink use master.
interface shift_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_shamt;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_shamt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_data, req0_shamt,
    input  req1_valid, req1_op, req1_data, req1_shamt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_data, req0_shamt,
    output req1_valid, req1_op, req1_data, req1_shamt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one sll/srl/sra datapath between two requesters, registered response.
// Define SHIFT_ARB_ROTATE_EN to make op 2'b11 a rotate right; otherwise it echoes the operand with rsp_err set.
module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             rr_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_id_r;
  logic             rsp_err_r;

  logic             can_accept_s;
  logic             grant_any_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [1:0]       op_s;
  logic [WIDTH-1:0] data_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] sll_s;
  logic [WIDTH-1:0] srl_s;
  logic [WIDTH-1:0] sra_s;
  logic [WIDTH-1:0] result_s;
  logic             err_s;

  // rr_r holds the requester favoured on the next contention; reset favours req0.
  always_comb begin
    grant_any_s = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_s = rr_r;
    end else if (bus.req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    can_accept_s = (state_r == IDLE) || ((state_r == RESP) && bus.rsp_ready);
    accept_s     = rst_n & can_accept_s & grant_any_s;
  end

  assign bus.req0_ready = accept_s & ~grant_id_s;
  assign bus.req1_ready = accept_s &  grant_id_s;

  assign sll_s = data_s << shamt_s;
  assign srl_s = data_s >> shamt_s;
  assign sra_s = $signed(data_s) >>> shamt_s;

`ifdef SHIFT_ARB_ROTATE_EN
  logic [WIDTH-1:0] rot_s;
  assign rot_s = WIDTH'({data_s, data_s} >> shamt_s);
`endif

  // Operand select from the granted requester and result select over the shared units.
  always_comb begin
    if (grant_id_s) begin
      op_s    = bus.req1_op;
      data_s  = bus.req1_data;
      shamt_s = bus.req1_shamt;
    end else begin
      op_s    = bus.req0_op;
      data_s  = bus.req0_data;
      shamt_s = bus.req0_shamt;
    end
    result_s = data_s;
    err_s    = 1'b0;
    case (op_s)
      2'b00: result_s = sll_s;
      2'b01: result_s = srl_s;
      2'b10: result_s = sra_s;
      2'b11: begin
`ifdef SHIFT_ARB_ROTATE_EN
        result_s = rot_s;
        err_s    = 1'b0;
`else
        result_s = data_s;
        err_s    = 1'b1;
`endif
      end
      default: begin
        result_s = data_s;
        err_s    = 1'b0;
      end
    endcase
  end

  // Next state: accepts keep/enter RESP, a consumed result with nothing new returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RESP;
        end else begin
          state_s = IDLE;
        end
      end
      RESP: begin
        if (accept_s) begin
          state_s = RESP;
        end else if (bus.rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, response registers and arbitration pointer; only an accept moves rr_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_r       <= 1'b0;
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_id_r   <= 1'b0;
      rsp_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        rr_r       <= ~grant_id_s;
        rsp_data_r <= result_s;
        rsp_id_r   <= grant_id_s;
        rsp_err_r  <= err_s;
      end
    end
  end

  assign bus.rsp_valid = (state_r == RESP);
  assign bus.busy      = (state_r == RESP);
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_err   = rsp_err_r;
endmodule
